// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared definitions for the binary32 -> int32 converter.
//   - state_t        : converter FSM states. ROUND exists only when
//                      FLOAT_TO_INT_ROUND_EN is defined.
//   - F32_BIAS       : binary32 exponent bias.
//   - INT_MAX/INT_MIN: saturation values for signed 32-bit results.
//   - SIGN_BIT, EXP_MSB, EXP_LSB, MANT_MSB : binary32 field positions.
// -----------------------------------------------------------------------------
package float_pkg;

    localparam int F32_BIAS = 127;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    // Fixed encodings keep the state numbering identical in both builds.
    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        UNPACK  = 3'd1,
        SPECIAL = 3'd2,
        CONVERT = 3'd3,
`ifdef FLOAT_TO_INT_ROUND_EN
        ROUND   = 3'd4,
`endif
        PACK    = 3'd5,
        PUT_Z   = 3'd6
    } state_t;

endpackage : float_pkg

// File: rtl/f2i_round.sv
// -----------------------------------------------------------------------------
// f2i_round
// Round-to-nearest-even increment decision for the aligned integer.
//   guard_i  : first bit shifted out below the integer LSB
//   sticky_i : OR of every bit shifted out below the guard bit
//   lsb_i    : current integer LSB (m[0])
//   inc_o    : 1 when the integer must be incremented
// Only instantiated when FLOAT_TO_INT_ROUND_EN is defined.
// -----------------------------------------------------------------------------
module f2i_round (
    input  logic guard_i,
    input  logic sticky_i,
    input  logic lsb_i,
    output logic inc_o
);

    // Above half rounds up; exactly half rounds up only from an odd value.
    assign inc_o = guard_i & (sticky_i | lsb_i);

endmodule : f2i_round

// File: rtl/float_to_int.sv
// -----------------------------------------------------------------------------
// float_to_int
// Converts an IEEE-754 binary32 value into a signed 32-bit integer over a
// strobe/acknowledge handshake. The mantissa is aligned by a one-bit-per-cycle
// shifter. Out-of-range values saturate, NaN yields NAN_VALUE, zero/denormal
// and |x| < 0.5-ish (e < -1) give 0.
//
// Build option: FLOAT_TO_INT_ROUND_EN
//   defined   -> round-to-nearest-even (extra ROUND cycle on the normal path)
//   undefined -> truncation toward zero
//
// Ports:
//   clk           : clock, all state on rising edge
//   rst           : synchronous active-high reset
//   input_a       : binary32 operand
//   input_a_stb   : producer has a valid operand
//   input_a_ack   : converter accepts the operand (registered)
//   output_z      : signed integer result
//   output_z_stb  : output_z valid
//   output_z_ack  : consumer takes output_z
// -----------------------------------------------------------------------------
module float_to_int
    import float_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_t             state_q;
    logic        [31:0] a_q;
    logic               s_q;
    logic signed [9:0]  e_q;
    logic        [31:0] m_q;
    logic               guard_q;
    logic               sticky_q;
    logic        [31:0] z_q;
    logic               a_ack_q;
    logic               z_stb_q;

    logic        [7:0]  exp_field_d;
    logic        [22:0] mant_field_d;
    logic signed [9:0]  e_unpack_d;
    logic signed [9:0]  e_inc_d;
    logic               is_nan_d;
    logic        [31:0] z_pack_d;

    assign exp_field_d  = a_q[EXP_MSB:EXP_LSB];
    assign mant_field_d = a_q[MANT_MSB:0];
    assign e_unpack_d   = signed'({2'b00, exp_field_d}) - 10'(F32_BIAS);
    assign e_inc_d      = e_q + 10'sd1;
    assign is_nan_d     = (exp_field_d == 8'hFF) && (mant_field_d != 23'd0);
    assign z_pack_d     = s_q ? (32'd0 - m_q) : m_q;

`ifdef FLOAT_TO_INT_ROUND_EN
    logic round_inc;

    f2i_round u_round (
        .guard_i  (guard_q),
        .sticky_i (sticky_q),
        .lsb_i    (m_q[0]),
        .inc_o    (round_inc)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= GET_A;
            a_q      <= '0;
            s_q      <= 1'b0;
            e_q      <= '0;
            m_q      <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            z_q      <= '0;
            a_ack_q  <= 1'b0;
            z_stb_q  <= 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (a_ack_q && input_a_stb) begin
                        a_q     <= input_a;
                        a_ack_q <= 1'b0;
                        state_q <= UNPACK;
                    end else begin
                        a_ack_q <= 1'b1;
                    end
                end

                UNPACK: begin
                    s_q      <= a_q[SIGN_BIT];
                    e_q      <= e_unpack_d;
                    // Hidden one at bit 31: m holds 1.f * 2^31.
                    m_q      <= {1'b1, a_q[MANT_MSB:0], 8'b0};
                    guard_q  <= 1'b0;
                    sticky_q <= 1'b0;
                    state_q  <= SPECIAL;
                end

                SPECIAL: begin
                    if (is_nan_d) begin
                        z_q     <= NAN_VALUE;
                        z_stb_q <= 1'b1;
                        state_q <= PUT_Z;
                    end else if (e_q >= 10'sd31) begin
                        // Also catches +-Inf and exactly -2^31.
                        z_q     <= s_q ? INT_MIN : INT_MAX;
                        z_stb_q <= 1'b1;
                        state_q <= PUT_Z;
                    end else if ((exp_field_d == 8'd0) || (e_q < -10'sd1)) begin
                        z_q     <= '0;
                        z_stb_q <= 1'b1;
                        state_q <= PUT_Z;
                    end else begin
                        state_q <= CONVERT;
                    end
                end

                CONVERT: begin
                    sticky_q <= sticky_q | guard_q;
                    guard_q  <= m_q[0];
                    m_q      <= m_q >> 1;
                    e_q      <= e_inc_d;
                    // The integer is aligned once e has been stepped up to 31.
                    if (e_q == 10'sd30) begin
`ifdef FLOAT_TO_INT_ROUND_EN
                        state_q <= ROUND;
`else
                        state_q <= PACK;
`endif
                    end
                end

`ifdef FLOAT_TO_INT_ROUND_EN
                ROUND: begin
                    // No overflow: for e = 30 the guard bit is always 0.
                    m_q     <= m_q + {31'd0, round_inc};
                    state_q <= PACK;
                end
`endif

                PACK: begin
                    z_q     <= z_pack_d;
                    z_stb_q <= 1'b1;
                    state_q <= PUT_Z;
                end

                PUT_Z: begin
                    if (output_z_ack) begin
                        z_stb_q <= 1'b0;
                        state_q <= GET_A;
                    end
                end

                default: begin
                    state_q <= GET_A;
                end
            endcase
        end
    end

    assign input_a_ack  = a_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

endmodule : float_to_int

// File: tb/tb_float_to_int.sv
// -----------------------------------------------------------------------------
// tb_float_to_int
// Directed self-checking bench for float_to_int. Expected integers are pushed
// into a scoreboard queue when an operand is sent and popped when the
// converter presents its result. Latency, backpressure and mid-operation reset
// behaviour are checked along the way. Honours FLOAT_TO_INT_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_float_to_int;

`ifdef FLOAT_TO_INT_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    float_to_int dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic put(input logic [31:0] a, input logic [31:0] expz, input bit track);
        int n;
        n = 0;
        input_a     = a;
        input_a_stb = 1'b1;
        while (input_a_ack !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ack_wait", {31'd0, n < 200}, 32'd1);
        if (track) exp_q.push_back(expz);
        @(posedge clk);
        @(negedge clk);
        input_a_stb = 1'b0;
        input_a     = 32'd0;
    endtask

    // Waits for the result, checks latency/value, optionally stalls the ack.
    task automatic get(input string tag, input int lat, input int hold);
        int n;
        logic [31:0] expz;
        n = 0;
        while (output_z_stb !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_stb"}, {31'd0, output_z_stb}, 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_sb"}, {31'd0, exp_q.size() != 0}, 32'd1);
        expz = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk(tag, output_z, expz);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_z"}, output_z, expz);
            chk({tag, "_hold_stb"}, {31'd0, output_z_stb}, 32'd1);
            chk({tag, "_hold_inack"}, {31'd0, input_a_ack}, 32'd0);
        end
        output_z_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        output_z_ack = 1'b0;
        chk({tag, "_stbdrop"}, {31'd0, output_z_stb}, 32'd0);
        chk({tag, "_inack0"}, {31'd0, input_a_ack}, 32'd0);
        if (hold > 0) begin
            @(negedge clk);
            chk({tag, "_inack1"}, {31'd0, input_a_ack}, 32'd1);
        end
        $display("[TB] %s z=%h expected=%h latency=%0d", tag, output_z, expz, n);
    endtask

    initial begin
        rst          = 1'b1;
        input_a      = 32'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
        chk("rst_z", output_z, 32'd0);
        chk("rst_inack", {31'd0, input_a_ack}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_inack0", {31'd0, input_a_ack}, 32'd0);
        @(negedge clk);
        chk("rel_inack1", {31'd0, input_a_ack}, 32'd1);

        // Normal path: latency 3 + k (+1 with rounding), k = 31 - e.
        put(32'h3F80_0000, 32'h0000_0001, 1'b1);
        get("one", 34 + RND, 0);
        put(32'hC2F6_E979, 32'hFFFF_FF85, 1'b1);
        get("neg123", 28 + RND, 0);
        put(32'h4020_0000, 32'd2, 1'b1);
        get("two_half", 33 + RND, 0);
        put(32'h4060_0000, (RND != 0) ? 32'd4 : 32'd3, 1'b1);
        get("three_half", 33 + RND, 0);
        put(32'h3F40_0000, (RND != 0) ? 32'd1 : 32'd0, 1'b1);
        get("p75", 35 + RND, 0);
        put(32'h3F00_0000, 32'd0, 1'b1);
        get("half", 35 + RND, 0);

        // Special path: latency 2.
        put(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1);
        get("pos_2p31", 2, 0);
        put(32'hCF00_0000, 32'h8000_0000, 1'b1);
        get("neg_2p31", 2, 0);
        put(32'h7FC0_0000, 32'h8000_0000, 1'b1);
        get("nan", 2, 0);
        put(32'h0000_0001, 32'd0, 1'b1);
        get("denorm", 2, 0);
        put(32'hFF80_0000, 32'h8000_0000, 1'b1);
        get("neg_inf", 2, 0);

        // Backpressure: 100.0 held for 5 cycles.
        put(32'h42C8_0000, 32'd100, 1'b1);
        get("bp_100", 28 + RND, 5);

        // Reset during CONVERT discards the operation.
        put(32'h3F80_0000, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_stb", {31'd0, output_z_stb}, 32'd0);
        chk("midrst_z", output_z, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_inack", {31'd0, input_a_ack}, 32'd1);
        put(32'h4120_0000, 32'h0000_000A, 1'b1);
        get("ten", 31 + RND, 0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_float_to_int
